// File: rtl/ram_fifo_ctrl.sv
// FIFO controller that uses an external single-port 16x4 RAM as storage, with a registered output stage.
// Optional macro FIFO_BYPASS_EN: a word pushed into an empty FIFO loads the output register directly.
module ram_fifo_ctrl #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_valid,
  input  logic [DATA_W-1:0] push_data,
  output logic              push_ready,
  output logic              pop_valid,
  output logic [DATA_W-1:0] pop_data,
  input  logic              pop_ready,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_wr,
  output logic              ram_rd,
  input  logic [DATA_W-1:0] ram_data_out
);

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] DEPTH = CW'(2**ADDR_W);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t            state;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [CW-1:0]     ram_cnt;
  logic              out_free;
  logic              refill;
  logic              push_fire;
  logic              bypass;

  always_comb begin
    out_free   = (!pop_valid || pop_ready) && (state != READ);
    refill     = out_free && (ram_cnt != '0);
    push_ready = rst_n && (ram_cnt < DEPTH) && !refill;
    push_fire  = push_valid && push_ready;
`ifdef FIFO_BYPASS_EN
    bypass     = !pop_valid && (ram_cnt == '0) && (state != READ);
`else
    bypass     = 1'b0;
`endif
  end

  // A word being read this cycle is already out of ram_cnt but not yet in pop_valid.
  assign count = ram_cnt + CW'(pop_valid) + CW'(state == READ);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      wptr        <= '0;
      rptr        <= '0;
      ram_cnt     <= '0;
      pop_valid   <= 1'b0;
      pop_data    <= '0;
      ram_address <= '0;
      ram_data_in <= '0;
      ram_wr      <= 1'b0;
      ram_rd      <= 1'b0;
    end else begin
      if (state == READ) begin
        pop_data  <= ram_data_out;
        pop_valid <= 1'b1;
      end else if (pop_valid && pop_ready) begin
        pop_valid <= 1'b0;
      end

      if (refill) begin
        state       <= READ;
        ram_rd      <= 1'b1;
        ram_wr      <= 1'b0;
        ram_address <= rptr;
        rptr        <= rptr + 1'b1;
        ram_cnt     <= ram_cnt - 1'b1;
      end else if (push_fire && bypass) begin
        state     <= IDLE;
        ram_rd    <= 1'b0;
        ram_wr    <= 1'b0;
        pop_data  <= push_data;
        pop_valid <= 1'b1;
      end else if (push_fire) begin
        state       <= WRITE;
        ram_rd      <= 1'b0;
        ram_wr      <= 1'b1;
        ram_address <= wptr;
        ram_data_in <= push_data;
        wptr        <= wptr + 1'b1;
        ram_cnt     <= ram_cnt + 1'b1;
      end else begin
        state  <= IDLE;
        ram_rd <= 1'b0;
        ram_wr <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Scoreboard bench for ram_fifo_ctrl: a queue model of accepted words is checked by a negedge monitor.
// Includes a behavioural 16x4 RAM; expectations adapt when FIFO_BYPASS_EN is defined.
module tb_ram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       push_valid = 1'b0;
  logic [3:0] push_data = '0;
  logic       push_ready;
  logic       pop_valid;
  logic [3:0] pop_data;
  logic       pop_ready = 1'b0;
  logic [4:0] count;
  logic [3:0] ram_address;
  logic [3:0] ram_data_in;
  logic       ram_wr;
  logic       ram_rd;
  logic [3:0] ram_data_out;

  logic [3:0] mem [16];
  logic [3:0] q [$];
  int         checks = 0;
  int         failures = 0;
  int         popped = 0;
  bit         armed = 0;

  ram_fifo_ctrl #(.DATA_W(4), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
    .pop_valid(pop_valid), .pop_data(pop_data), .pop_ready(pop_ready),
    .count(count), .ram_address(ram_address), .ram_data_in(ram_data_in),
    .ram_wr(ram_wr), .ram_rd(ram_rd), .ram_data_out(ram_data_out)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 16; i++) mem[i] = '0;
  always @(posedge clk) if (ram_wr) mem[ram_address] <= ram_data_in;
  assign ram_data_out = mem[ram_address];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: observe the registered state, then record the handshakes of the upcoming edge.
  always @(negedge clk) begin
    if (armed) begin
      chk("count", int'(count), q.size());
      chk("wr_rd_excl", int'(ram_wr & ram_rd), 0);
      if (q.size() >= 17) chk("full_push_ready", int'(push_ready), 0);
    end
    if (!rst_n) begin
      chk("rst_push_ready", int'(push_ready), 0);
      q.delete();
      armed = 1;
    end else if (armed) begin
      if (pop_valid && pop_ready) begin
        if (q.size() == 0) chk("pop_underflow", 1, 0);
        else chk("pop_data", int'(pop_data), int'(q.pop_front()));
        popped++;
      end
      if (push_valid && push_ready) q.push_back(push_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [3:0] d);
    bit ok = 0;
    push_valid = 1'b1;
    push_data  = d;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = push_ready;
      tick();
    end
    push_valid = 1'b0;
    if (!ok) chk("push_timeout", 0, 1);
  endtask

  task automatic drain();
    bit done = 0;
    pop_ready = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      tick();
      if (q.size() == 0 && !pop_valid && count == 0) done = 1;
    end
    pop_ready = 1'b0;
    if (!done) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    int target;
    bit reached;
    repeat (2) tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_count", int'(count), 0);
    chk("reset_pop_valid", int'(pop_valid), 0);
    chk("reset_wr_rd", int'({ram_wr, ram_rd}), 0);
    tick();

    // Single push latency
    push_valid = 1'b1; push_data = 4'hA; pop_ready = 1'b0;
    tick();
    push_valid = 1'b0;
    @(negedge clk);
`ifdef FIFO_BYPASS_EN
    chk("byp_pop_valid", int'(pop_valid), 1);
    chk("byp_pop_data", int'(pop_data), 'hA);
    chk("byp_no_wr", int'(ram_wr), 0);
`else
    chk("lat_wr", int'(ram_wr), 1);
    chk("lat_wr_addr", int'(ram_address), 0);
    chk("lat_wr_data", int'(ram_data_in), 'hA);
    tick();
    @(negedge clk);
    chk("lat_rd", int'(ram_rd), 1);
    chk("lat_rd_addr", int'(ram_address), 0);
    chk("lat_pv_early", int'(pop_valid), 0);
    tick();
    @(negedge clk);
    chk("lat_pop_valid", int'(pop_valid), 1);
    chk("lat_pop_data", int'(pop_data), 'hA);
    chk("lat_count", int'(count), 1);
`endif
    drain();

    // Fill to 17 words, then drain in order
    for (int i = 0; i < 16; i++) push_word(4'(i));
    push_word(4'h1);
    push_valid = 1'b1; push_data = 4'h5;
    @(negedge clk);
    chk("full_count", int'(count), 17);
    chk("full_ready", int'(push_ready), 0);
    tick();
    push_valid = 1'b0;
    drain();

`ifndef FIFO_BYPASS_EN
    // Push offered while a refill is pending stalls for one cycle
    push_valid = 1'b1; push_data = 4'h9;
    tick();
    push_data = 4'h6;
    @(negedge clk);
    chk("refill_stall", int'(push_ready), 0);
    tick();
    @(negedge clk);
    chk("after_stall_ready", int'(push_ready), 1);
    tick();
    push_valid = 1'b0;
    drain();
`endif

    // Reset during a READ cycle with five words held
    for (int i = 0; i < 6; i++) push_word(4'($urandom_range(0, 15)));
    repeat (2) tick();
    pop_ready = 1'b1;
    tick();
    pop_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("pre_rst_rd", int'(ram_rd), 1);
    chk("pre_rst_count", int'(count), 5);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_count", int'(count), 0);
    chk("post_rst_pop_valid", int'(pop_valid), 0);
    chk("post_rst_rd", int'(ram_rd), 0);
    tick();
    push_word(4'h3);
    drain();

    // Random concurrent push/pop over at least 40 words
    target = popped + 40;
    reached = 0;
    for (int i = 0; i < 3000 && !reached; i++) begin
      push_valid = ($urandom_range(0, 3) != 0);
      push_data  = 4'($urandom_range(0, 15));
      pop_ready  = ($urandom_range(0, 2) != 0);
      tick();
      if (popped >= target) reached = 1;
    end
    push_valid = 1'b0;
    if (!reached) chk("random_timeout", 0, 1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
